// File: rtl/register_file_param.sv
// Parametrised general-purpose register file: two registered byte read ports,
// one registered register-pair read port, one byte write port and one pair
// write port, with optional write-first bypass and a read-hold input.
module register_file_param #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 5,
  parameter int BYPASS    = 1
) (
  input  logic                   clock,
  input  logic                   clr_n,
  input  logic [ADDR_BITS-1:0]   RA1,
  input  logic [ADDR_BITS-1:0]   RA2,
  input  logic [ADDR_BITS-2:0]   PRA,
  input  logic                   RE,
  input  logic [ADDR_BITS-1:0]   WA,
  input  logic                   RegWrite,
  input  logic [WIDTH-1:0]       WD,
  input  logic                   PairWrite,
  input  logic [ADDR_BITS-2:0]   PWA,
  input  logic [2*WIDTH-1:0]     PWD,
  output logic [WIDTH-1:0]       RD1,
  output logic [WIDTH-1:0]       RD2,
  output logic [2*WIDTH-1:0]     RDP
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0]     regs    [DEPTH];
  logic [DEPTH-1:0]     wr_en;
  logic [WIDTH-1:0]     wr_data [DEPTH];
  logic                 byte_in_pair;
  logic [ADDR_BITS-1:0] pair_lo_addr;
  logic [ADDR_BITS-1:0] pair_hi_addr;
  logic [WIDTH-1:0]     rd1_nxt;
  logic [WIDTH-1:0]     rd2_nxt;
  logic [WIDTH-1:0]     rdp_lo_nxt;
  logic [WIDTH-1:0]     rdp_hi_nxt;

  // Byte write is dropped when it lands inside the pair being written.
  assign byte_in_pair = PairWrite && (WA[ADDR_BITS-1:1] == PWA);
  assign pair_lo_addr = {PRA, 1'b0};
  assign pair_hi_addr = {PRA, 1'b1};

  // Per-register write enable and data, pair write taking priority
  always_comb begin
    wr_en = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_data[i] = '0;
      if (PairWrite && (PWA == (ADDR_BITS-1)'(i >> 1))) begin
        wr_en[i]   = 1'b1;
        wr_data[i] = ((i % 2) == 1) ? PWD[2*WIDTH-1:WIDTH] : PWD[WIDTH-1:0];
      end else if (RegWrite && !byte_in_pair && (WA == ADDR_BITS'(i))) begin
        wr_en[i]   = 1'b1;
        wr_data[i] = WD;
      end
    end
  end

  // Read data selection, forwarding same-edge writes when bypass is enabled
  always_comb begin
    rd1_nxt    = regs[RA1];
    rd2_nxt    = regs[RA2];
    rdp_lo_nxt = regs[pair_lo_addr];
    rdp_hi_nxt = regs[pair_hi_addr];
    if (BYPASS != 0) begin
      if (wr_en[RA1])          rd1_nxt    = wr_data[RA1];
      if (wr_en[RA2])          rd2_nxt    = wr_data[RA2];
      if (wr_en[pair_lo_addr]) rdp_lo_nxt = wr_data[pair_lo_addr];
      if (wr_en[pair_hi_addr]) rdp_hi_nxt = wr_data[pair_hi_addr];
    end
  end

  // Register storage update
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) regs[i] <= wr_data[i];
      end
    end
  end

  // Registered read outputs, held while RE is low
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      RD1 <= '0;
      RD2 <= '0;
      RDP <= '0;
    end else if (RE) begin
      RD1 <= rd1_nxt;
      RD2 <= rd2_nxt;
      RDP <= {rdp_hi_nxt, rdp_lo_nxt};
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
module tb_register_file_param;

  logic clock = 1'b0;
  logic clr_n = 1'b1;
  always #5 clock = ~clock;

  // Default instance: WIDTH=8, ADDR_BITS=5, BYPASS=1
  logic        re, rw, pw;
  logic [4:0]  ra1, ra2, wa;
  logic [3:0]  pra, pwa;
  logic [7:0]  wd, rd1, rd2;
  logic [15:0] pwd, rdp;

  register_file_param dut (
    .clock(clock), .clr_n(clr_n), .RA1(ra1), .RA2(ra2), .PRA(pra), .RE(re),
    .WA(wa), .RegWrite(rw), .WD(wd), .PairWrite(pw), .PWA(pwa), .PWD(pwd),
    .RD1(rd1), .RD2(rd2), .RDP(rdp)
  );

  // Read-old instance
  logic        n_re, n_rw, n_pw;
  logic [4:0]  n_ra1, n_ra2, n_wa;
  logic [3:0]  n_pra, n_pwa;
  logic [7:0]  n_wd, n_rd1, n_rd2;
  logic [15:0] n_pwd, n_rdp;

  register_file_param #(.WIDTH(8), .ADDR_BITS(5), .BYPASS(0)) dut_nb (
    .clock(clock), .clr_n(clr_n), .RA1(n_ra1), .RA2(n_ra2), .PRA(n_pra), .RE(n_re),
    .WA(n_wa), .RegWrite(n_rw), .WD(n_wd), .PairWrite(n_pw), .PWA(n_pwa), .PWD(n_pwd),
    .RD1(n_rd1), .RD2(n_rd2), .RDP(n_rdp)
  );

  // Wide instance: WIDTH=16, ADDR_BITS=3
  logic        w_re, w_rw, w_pw;
  logic [2:0]  w_ra1, w_ra2, w_wa;
  logic [1:0]  w_pra, w_pwa;
  logic [15:0] w_wd, w_rd1, w_rd2;
  logic [31:0] w_pwd, w_rdp;

  register_file_param #(.WIDTH(16), .ADDR_BITS(3), .BYPASS(1)) dut_w (
    .clock(clock), .clr_n(clr_n), .RA1(w_ra1), .RA2(w_ra2), .PRA(w_pra), .RE(w_re),
    .WA(w_wa), .RegWrite(w_rw), .WD(w_wd), .PairWrite(w_pw), .PWA(w_pwa), .PWD(w_pwd),
    .RD1(w_rd1), .RD2(w_rd2), .RDP(w_rdp)
  );

  typedef struct {
    logic        re;
    logic [4:0]  ra1, ra2;
    logic [3:0]  pra;
    logic        rw;
    logic [4:0]  wa;
    logic [7:0]  wd;
    logic        pw;
    logic [3:0]  pwa;
    logic [15:0] pwd;
    logic [7:0]  e1, e2;
    logic [15:0] ep;
  } vec_t;

  typedef struct {
    logic [7:0]  e1, e2;
    logic [15:0] ep;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[17];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(int r, int a1, int a2, int pa, int bw, int bwa, int bwd,
                              int pwr, int pwi, int pwdat, int x1, int x2, int xp);
    vec_t v;
    v.re = 1'(r);   v.ra1 = 5'(a1);  v.ra2 = 5'(a2);  v.pra = 4'(pa);
    v.rw = 1'(bw);  v.wa = 5'(bwa);  v.wd = 8'(bwd);
    v.pw = 1'(pwr); v.pwa = 4'(pwi); v.pwd = 16'(pwdat);
    v.e1 = 8'(x1);  v.e2 = 8'(x2);   v.ep = 16'(xp);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic idle_all();
    re = 1'b1; rw = 1'b0; pw = 1'b0; ra1 = '0; ra2 = '0; pra = '0;
    wa = '0; wd = '0; pwa = '0; pwd = '0;
    n_re = 1'b1; n_rw = 1'b0; n_pw = 1'b0; n_ra1 = '0; n_ra2 = '0; n_pra = '0;
    n_wa = '0; n_wd = '0; n_pwa = '0; n_pwd = '0;
    w_re = 1'b1; w_rw = 1'b0; w_pw = 1'b0; w_ra1 = '0; w_ra2 = '0; w_pra = '0;
    w_wa = '0; w_wd = '0; w_pwa = '0; w_pwd = '0;
  endtask

  // Drive one vector at the falling edge, push its expectation, compare after the rising edge
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clock);
    re = v.re; ra1 = v.ra1; ra2 = v.ra2; pra = v.pra;
    rw = v.rw; wa = v.wa; wd = v.wd;
    pw = v.pw; pwa = v.pwa; pwd = v.pwd;
    exp_q.push_back('{e1: v.e1, e2: v.e2, ep: v.ep});
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rd1"}, 32'(rd1), 32'(e.e1));
      check({tag, "_rd2"}, 32'(rd2), 32'(e.e2));
      check({tag, "_rdp"}, 32'(rdp), 32'(e.ep));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_all();

    // Vector table (BYPASS=1 instance), starting from an all-zero file
    vecs[0]  = mk(1,  0,  0,  0, 1,  3, 'hA5, 0,  0, 'h0000, 'h00, 'h00, 'h0000);
    vecs[1]  = mk(1,  3,  2,  1, 0,  0, 'h00, 0,  0, 'h0000, 'hA5, 'h00, 'hA500);
    vecs[2]  = mk(1,  0,  0,  0, 0,  0, 'h00, 1, 13, 'hBEEF, 'h00, 'h00, 'h0000);
    vecs[3]  = mk(1, 26, 27, 13, 0,  0, 'h00, 0,  0, 'h0000, 'hEF, 'hBE, 'hBEEF);
    vecs[4]  = mk(1, 26, 27, 13, 1, 27, 'h11, 1, 13, 'h1234, 'h34, 'h12, 'h1234);
    vecs[5]  = mk(1, 26, 27, 13, 0,  0, 'h00, 0,  0, 'h0000, 'h34, 'h12, 'h1234);
    vecs[6]  = mk(1,  5, 26, 13, 1,  5, 'h77, 1, 13, 'hCAFE, 'h77, 'hFE, 'hCAFE);
    vecs[7]  = mk(1,  5, 27,  2, 0,  0, 'h00, 0,  0, 'h0000, 'h77, 'hCA, 'h7700);
    vecs[8]  = mk(1, 10, 11,  5, 1, 10, 'h5A, 0,  0, 'h0000, 'h5A, 'h00, 'h005A);
    vecs[9]  = mk(1, 10, 11,  5, 1, 11, 'h3C, 0,  0, 'h0000, 'h5A, 'h3C, 'h3C5A);
    vecs[10] = mk(0,  3,  0,  0, 1, 10, 'hC3, 0,  0, 'h0000, 'h5A, 'h3C, 'h3C5A);
    vecs[11] = mk(0, 26,  1,  9, 0,  0, 'h00, 0,  0, 'h0000, 'h5A, 'h3C, 'h3C5A);
    vecs[12] = mk(0,  5,  2,  2, 0,  0, 'h00, 0,  0, 'h0000, 'h5A, 'h3C, 'h3C5A);
    vecs[13] = mk(1, 10, 11,  5, 0,  0, 'h00, 0,  0, 'h0000, 'hC3, 'h3C, 'h3CC3);
    vecs[14] = mk(1, 31,  0, 15, 1,  0, 'h99, 1, 15, 'hDEAD, 'hDE, 'h99, 'hDEAD);
    vecs[15] = mk(1, 30, 31, 15, 1, 30, 'h55, 1, 15, 'hF00D, 'h0D, 'hF0, 'hF00D);
    vecs[16] = mk(1,  0,  1,  0, 0,  0, 'h00, 0,  0, 'h0000, 'h99, 'h00, 'h0099);

    // Asynchronous reset asserted mid-cycle
    #3 clr_n = 1'b0;
    #1;
    check("rst_rd1", 32'(rd1), 32'h0);
    check("rst_rd2", 32'(rd2), 32'h0);
    check("rst_rdp", 32'(rdp), 32'h0);
    check("rst_w_rdp", w_rdp, 32'h0);
    @(negedge clock);
    clr_n = 1'b1;

    for (int i = 0; i < 17; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Mid-cycle reset clears outputs immediately
    #2 clr_n = 1'b0;
    #1;
    check("midrst_rd1", 32'(rd1), 32'h0);
    check("midrst_rd2", 32'(rd2), 32'h0);
    check("midrst_rdp", 32'(rdp), 32'h0);
    // Write and read attempted on an edge while reset is held
    @(negedge clock);
    rw = 1'b1; wa = 5'd3; wd = 8'hFF; ra1 = 5'd3; pra = 4'd1;
    @(posedge clock);
    #1;
    check("held_rd1", 32'(rd1), 32'h0);
    check("held_rdp", 32'(rdp), 32'h0);
    #1 clr_n = 1'b1;
    // First edge after release performs its write and read normally
    apply(mk(1, 7, 3, 13, 1, 7, 'h42, 0, 0, 'h0000, 'h42, 'h00, 'h0000), "release");
    apply(mk(1, 3, 7, 1, 0, 0, 'h00, 0, 0, 'h0000, 'h00, 'h42, 'h0000), "after_rel");

    // Read-old instance: same-edge writes appear one edge later
    @(negedge clock);
    n_rw = 1'b1; n_wa = 5'd10; n_wd = 8'h5A; n_ra1 = 5'd10;
    n_pw = 1'b1; n_pwa = 4'd3; n_pwd = 16'hABCD; n_pra = 4'd3; n_ra2 = 5'd7;
    @(posedge clock);
    #1;
    check("nb_old_rd1", 32'(n_rd1), 32'h00);
    check("nb_old_rd2", 32'(n_rd2), 32'h00);
    check("nb_old_rdp", 32'(n_rdp), 32'h0000);
    @(negedge clock);
    n_rw = 1'b0; n_pw = 1'b0;
    @(posedge clock);
    #1;
    check("nb_new_rd1", 32'(n_rd1), 32'h5A);
    check("nb_new_rd2", 32'(n_rd2), 32'hAB);
    check("nb_new_rdp", 32'(n_rdp), 32'hABCD);

    // Wide instance: WIDTH=16, ADDR_BITS=3
    @(negedge clock);
    w_rw = 1'b1; w_wa = 3'd7; w_wd = 16'hFFFF;
    w_pw = 1'b1; w_pwa = 2'd0; w_pwd = 32'h0001_0002;
    @(negedge clock);
    w_rw = 1'b0; w_pw = 1'b0; w_ra1 = 3'd7; w_ra2 = 3'd1; w_pra = 2'd0;
    @(posedge clock);
    #1;
    check("w_rd1", 32'(w_rd1), 32'hFFFF);
    check("w_rd2", 32'(w_rd2), 32'h0001);
    check("w_rdp", w_rdp, 32'h0001_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
